// File: rtl/botones_pkg.sv
// Shared definitions for the push-button blocks: FSM state encoding and default parameter values.
// The auto-repeat defaults are only consumed when BOTON_AUTOREPEAT_EN is defined.
package botones_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } estado_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 16;
  localparam int DEF_REPEAT_DELAY    = 20;
  localparam int DEF_REPEAT_PERIOD   = 8;

endpackage

// File: rtl/boton_pulso_toggle_sync.sv
// Two-flop synchronizer bringing an asynchronous input into the Clk domain.
// Both flops clear asynchronously on reset.
module sincronizador_2ff (
  input  logic Clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/boton_pulso_toggle.sv
// Debounced push-button producing a one-cycle pulse per accepted press (drives FlipT enable).
// Optional auto-repeat while held is enabled by defining BOTON_AUTOREPEAT_EN.
module boton_pulso_toggle
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef BOTON_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  estado_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pulse_n, level_n, busy_n;

`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic             rep, rep_n;
`endif

  sincronizador_2ff u_sync (
    .Clk   (Clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b0;
`ifdef BOTON_AUTOREPEAT_EN
      rcnt  <= '0;
      rep   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pulse <= pulse_n;
      level <= level_n;
      busy  <= busy_n;
`ifdef BOTON_AUTOREPEAT_EN
      rcnt  <= rcnt_n;
      rep   <= rep_n;
`endif
    end
  end

  // level/busy follow the next state so they change on the same edge as the FSM.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s2) begin
          state_n = ST_ARM_PRESS;
          cnt_n   = '0;
        end
      end
      ST_ARM_PRESS: begin
        if (!s2) begin
          state_n = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HELD;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!s2) begin
          state_n = ST_ARM_RELEASE;
          cnt_n   = '0;
        end
      end
      ST_ARM_RELEASE: begin
        if (s2) begin
          state_n = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef BOTON_AUTOREPEAT_EN
    rcnt_n = rcnt;
    rep_n  = rep;
    // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
    if (state_n == ST_HELD && state != ST_HELD) begin
      rcnt_n = '0;
      rep_n  = 1'b0;
    end else if (state == ST_HELD && s2) begin
      if (rcnt == (rep ? RPT_NEXT : RPT_FIRST)) begin
        pulse_n = 1'b1;
        rcnt_n  = '0;
        rep_n   = 1'b1;
      end else begin
        rcnt_n = rcnt + 1'b1;
      end
    end
`endif

    level_n = (state_n == ST_HELD) || (state_n == ST_ARM_RELEASE);
    busy_n  = (state_n == ST_ARM_PRESS) || (state_n == ST_ARM_RELEASE);
  end

endmodule
